tx_block: RTL and testbench

//  Serial frame transmitter: takes a parallel byte and drives it onto a single

---
 rtl/tx_pkg.sv | 7 +
 rtl/bit_timer.sv | 21 ++
 rtl/tx_block.sv | 83 ++++++++
 tb/tb_tx_block.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared FSM state type and serial line levels for the transmit path.
package tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic IDLE_LINE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: wrapping up-counter that counts 0..rollover_val-1.
//   clk, n_rst (async, active low), clear (sync, to 0), count_enable,
//   rollover_val (period), rollover_flag (enabled and at last count).
module bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH:0]   rollover_val,
    output logic             rollover_flag
);
    logic [WIDTH-1:0] count;
    assign rollover_flag = count_enable && ({1'b0, count} == rollover_val - 1'b1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count <= '0;
        else if (clear) count <= '0;
        else if (count_enable) count <= rollover_flag ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/tx_block.sv
// tx_block: serial frame transmitter (start, data LSB first, optional parity, stop).
//   clk, n_rst (async, active low), tx_data (latched on accept), tx_start,
//   tx_ready (idle), tx_done (one-cycle pulse at end of stop bit), serial_out (idles 1).
//   Define TX_PARITY_EN to insert an even-parity bit after the data bits.
module tx_block
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 serial_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    tx_state_t state;
    logic [DATA_BITS-1:0] shreg;
    logic clk_flag, bit_flag;
    bit_timer #(.WIDTH(CW)) clk_timer (
        .clk(clk), .n_rst(n_rst),
        .clear(state == IDLE), .count_enable(state != IDLE),
        .rollover_val((CW+1)'(CLKS_PER_BIT)), .rollover_flag(clk_flag)
    );
    bit_timer #(.WIDTH(BW)) bit_counter (
        .clk(clk), .n_rst(n_rst),
        .clear(state != DATA), .count_enable(state == DATA && clk_flag),
        .rollover_val((BW+1)'(DATA_BITS)), .rollover_flag(bit_flag)
    );
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shreg      <= '0;
            serial_out <= IDLE_LINE;
            tx_ready   <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: if (tx_start) begin
                    state      <= START;
                    shreg      <= tx_data;
                    serial_out <= START_BIT;
                    tx_ready   <= 1'b0;
                end
                START: if (clk_flag) begin
                    state      <= DATA;
                    serial_out <= shreg[0];
                end
                DATA: if (clk_flag) begin
                    if (bit_flag) begin
`ifdef TX_PARITY_EN
                        // shreg is rotated, so all latched bits are still present
                        state      <= PARITY;
                        serial_out <= ^shreg;
`else
                        state      <= STOP;
                        serial_out <= STOP_BIT;
`endif
                    end else begin
                        shreg      <= {shreg[0], shreg[DATA_BITS-1:1]};
                        serial_out <= shreg[1];
                    end
                end
                PARITY: if (clk_flag) begin
                    state      <= STOP;
                    serial_out <= STOP_BIT;
                end
                STOP: if (clk_flag) begin
                    state      <= IDLE;
                    serial_out <= IDLE_LINE;
                    tx_done    <= 1'b1;
                    tx_ready   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_block.sv
// tb_tx_block: randomized and directed checks of tx_block against a frame-level model.
`timescale 1ns/100ps
module tb_tx_block;
    localparam int C = 10;
`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 10 + P;
    localparam int FLEN = NB * C;

    logic clk = 1'b0;
    logic n_rst;
    logic [7:0] tx_data;
    logic tx_start;
    logic tx_ready, tx_done, serial_out;
    int checks = 0;
    int errors = 0;

    tx_block #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_start(tx_start),
        .tx_ready(tx_ready), .tx_done(tx_done), .serial_out(serial_out)
    );

    always #0.5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a list of NB bits each lasting C cycles.
    bit busy = 0;
    bit m_done = 0;
    int t = 0;
    bit frame [0:10];
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            busy = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (busy) begin
                t++;
                if (t == FLEN) begin
                    busy = 0;
                    m_done = 1;
                end
            end else if (tx_start) begin
                busy = 1;
                t = 0;
                frame[0] = 1'b0;
                for (int i = 0; i < 8; i++) frame[1+i] = tx_data[i];
                if (P == 1) frame[9] = ^tx_data;
                frame[9+P] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("serial_out", serial_out, busy ? frame[t / C] : 1'b1);
        chk("tx_ready", tx_ready, !busy);
        chk("tx_done", tx_done, m_done);
    end

    // Sends one frame, optionally injecting a tx_start at cycle inj of the frame,
    // samples each bit at mid-period and waits for tx_done (bounded).
    task automatic send(input logic [7:0] d, input int inj, input bit lit, input logic [10:0] exp_v);
        logic [10:0] got;
        int cyc;
        bit seen;
        got = '0;
        seen = 0;
        cyc = 0;
        tx_data = d;
        tx_start = 1'b1;
        @(posedge clk);
        while (!seen && cyc <= FLEN + 20) begin
            @(negedge clk);
            if (cyc == 0) begin
                tx_start = 1'b0;
                tx_data = 8'($urandom);
            end
            if (cyc == inj) begin
                tx_start = 1'b1;
                tx_data = 8'h3C;
            end else if (cyc == inj + 1) tx_start = 1'b0;
            if (cyc % C == C / 2 && cyc / C < NB) got[cyc / C] = serial_out;
            if (tx_done) begin
                seen = 1;
                chk("done_latency", cyc, FLEN);
            end else cyc++;
        end
        tx_start = 1'b0;
        chk("done_seen", {31'b0, seen}, 1);
        if (lit) chk("frame_bits", got, exp_v);
    endtask

    initial begin
        n_rst = 1'b0;
        tx_start = 1'b0;
        tx_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_serial", serial_out, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_done", tx_done, 1'b0);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_serial", serial_out, 1'b1);
        chk("post_rst_ready", tx_ready, 1'b1);

        send(8'hA5, -1, 1, P ? 11'h54A : 11'h34A);
        repeat (5) @(negedge clk);

        send(8'h00, -1, 1, P ? 11'h400 : 11'h200);
        send(8'hFF, -1, 1, P ? 11'h5FE : 11'h3FE);
        repeat (4) @(negedge clk);

        send(8'h96, 20, 1, P ? 11'h52C : 11'h32C);
        repeat (C * 15) @(negedge clk);

        tx_data = 8'h5A;
        tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (44) @(negedge clk);
        #0.2 n_rst = 1'b0;
        #0.1;
        chk("midrst_serial", serial_out, 1'b1);
        chk("midrst_ready", tx_ready, 1'b1);
        chk("midrst_done", tx_done, 1'b0);
        repeat (2) @(negedge clk);
        #0.2 n_rst = 1'b1;
        repeat (C * 12) @(negedge clk);
        send(8'h5A, -1, 1, P ? 11'h4B4 : 11'h2B4);
        repeat (2) @(negedge clk);

        if (P == 1) begin
            send(8'h07, -1, 1, 11'h60E);
            send(8'h03, -1, 1, 11'h406);
        end

        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(8'($urandom), $urandom_range(0, 1) ? int'($urandom_range(1, FLEN - 2)) : -1, 0, '0);
        end
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
